// File: rtl/qed_dup_buffer_if.sv
// Instruction handshake bundle between fetch, the QED duplication buffer and the decoder.
// The master modport is the fetch/decoder side; the slave modport is the buffer.
interface qed_dup_buffer_if;
    logic [31:0] inst_in;
    logic        inst_in_valid;
    logic        inst_in_ready;
    logic [31:0] inst_out;
    logic        inst_out_valid;
    logic        inst_out_ready;

    modport master (
        output inst_in, inst_in_valid, inst_out_ready,
        input  inst_in_ready, inst_out, inst_out_valid
    );

    modport slave (
        input  inst_in, inst_in_valid, inst_out_ready,
        output inst_in_ready, inst_out, inst_out_valid
    );
endinterface

// File: rtl/qed_dup_buffer.sv
// QED duplication buffer: records original instructions (x0-x15) in the ORIG phase,
// replays them with register fields remapped to x16-x31 in the DUP phase, then waits
// in WAIT until every instruction of the pass has committed.
// Optional feature macro QED_STORE_REMAP_EN: when defined, stores are replayed with
// rs1/rs2 remapped; when undefined, replayed stores become a NOP.
module qed_dup_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    qed_dup_buffer_if.slave      bus,
    input  logic                 qed_ena,
    input  logic                 qed_switch,
    input  logic                 commit,
    output logic                 dup_mode,
    output logic [ADDR_W:0]      num_orig_insts,
    output logic [ADDR_W:0]      num_dup_insts,
    output logic                 wait_till_commit,
    output logic                 wait_till_commit_reg,
    output logic                 chk_en
);

    typedef enum logic [1:0] {S_ORIG, S_DUP, S_WAIT} state_t;

    localparam logic [ADDR_W:0]   FULL    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W+1:0] CNT_MAX = (ADDR_W+2)'(2 * DEPTH);

    state_t              state;
    state_t              next_state;
    logic [31:0]         mem [DEPTH];
    logic [ADDR_W-1:0]   head;
    logic [ADDR_W-1:0]   tail;
    logic [ADDR_W+1:0]   commit_cnt;
    logic [ADDR_W+1:0]   commit_total;
    logic [ADDR_W+1:0]   pass_target;
    logic                has_room;
    logic                in_xfer;
    logic                out_xfer;
    logic                record;
    logic                replay;
    logic                pass_done;

    // Register fields get bit 4 set (x[n] -> x[n+16]); x0 always stays x0.
    function automatic logic [31:0] remap(input logic [31:0] inst);
        logic [31:0] r;
        r = inst;
        case (inst[6:0])
            7'b0110011: begin
                if (inst[11:7]  != 5'd0) r[11] = 1'b1;
                if (inst[19:15] != 5'd0) r[19] = 1'b1;
                if (inst[24:20] != 5'd0) r[24] = 1'b1;
            end
            7'b0010011, 7'b0000011: begin
                if (inst[11:7]  != 5'd0) r[11] = 1'b1;
                if (inst[19:15] != 5'd0) r[19] = 1'b1;
            end
            7'b0110111: begin
                if (inst[11:7]  != 5'd0) r[11] = 1'b1;
            end
            7'b0100011: begin
`ifdef QED_STORE_REMAP_EN
                if (inst[19:15] != 5'd0) r[19] = 1'b1;
                if (inst[24:20] != 5'd0) r[24] = 1'b1;
`else
                r = 32'h0000_0013;
`endif
            end
            default: r = inst;
        endcase
        return r;
    endfunction

    assign has_room     = (num_orig_insts < FULL);
    assign in_xfer      = bus.inst_in_valid & bus.inst_in_ready;
    assign out_xfer     = bus.inst_out_valid & bus.inst_out_ready;
    assign record       = qed_ena & (state == S_ORIG) & in_xfer;
    assign replay       = qed_ena & (state == S_DUP) & out_xfer;
    assign commit_total = (commit_cnt == CNT_MAX) ? CNT_MAX
                                                  : commit_cnt + {{(ADDR_W+1){1'b0}}, commit};
    assign pass_target  = {1'b0, num_orig_insts} + {1'b0, num_dup_insts};
    assign pass_done    = qed_ena & (state == S_WAIT) & (commit_total == pass_target);
    assign dup_mode         = (state == S_DUP);
    assign wait_till_commit = (state == S_WAIT);

    // Handshake steering and next-state selection; everything is forced quiet while reset is held.
    // In ORIG the outgoing valid is also gated by free space so the decoder can never take an
    // instruction that fetch has not handed over.
    always_comb begin
        next_state         = state;
        bus.inst_out       = 32'h0;
        bus.inst_out_valid = 1'b0;
        bus.inst_in_ready  = 1'b0;
        if (rst) begin
            if (!qed_ena) begin
                bus.inst_out       = bus.inst_in;
                bus.inst_out_valid = bus.inst_in_valid;
                bus.inst_in_ready  = bus.inst_out_ready;
                next_state         = S_ORIG;
            end else begin
                case (state)
                    S_ORIG: begin
                        bus.inst_out       = bus.inst_in;
                        bus.inst_out_valid = bus.inst_in_valid & has_room;
                        bus.inst_in_ready  = bus.inst_out_ready & has_room;
                        if (!has_room || (qed_switch && num_orig_insts != '0))
                            next_state = S_DUP;
                    end
                    S_DUP: begin
                        bus.inst_out       = remap(mem[head]);
                        bus.inst_out_valid = 1'b1;
                        if (bus.inst_out_ready && ((num_dup_insts + 1'b1) == num_orig_insts))
                            next_state = S_WAIT;
                    end
                    S_WAIT: begin
                        if (commit_total == pass_target)
                            next_state = S_ORIG;
                    end
                    default: next_state = S_ORIG;
                endcase
            end
        end
    end

    // Control state: FSM, pointers, pass counters and the completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= S_ORIG;
            head                 <= '0;
            tail                 <= '0;
            num_orig_insts       <= '0;
            num_dup_insts        <= '0;
            commit_cnt           <= '0;
            wait_till_commit_reg <= 1'b0;
            chk_en               <= 1'b0;
        end else begin
            state                <= next_state;
            chk_en               <= qed_ena;
            wait_till_commit_reg <= pass_done;
            if (!qed_ena || pass_done) begin
                head           <= '0;
                tail           <= '0;
                num_orig_insts <= '0;
                num_dup_insts  <= '0;
                commit_cnt     <= '0;
            end else begin
                commit_cnt <= commit_total;
                if (record) begin
                    tail           <= tail + 1'b1;
                    num_orig_insts <= num_orig_insts + 1'b1;
                end
                if (replay) begin
                    head          <= head + 1'b1;
                    num_dup_insts <= num_dup_insts + 1'b1;
                end
            end
        end
    end

    // Instruction storage; contents are don't-care after reset because the pointers restart.
    always_ff @(posedge clk) begin
        if (record)
            mem[tail] <= bus.inst_in;
    end

endmodule

// File: tb/tb_qed_dup_buffer.sv
// Directed bench for qed_dup_buffer: short pass with switch, full auto-switch pass with
// mixed opcodes and a stall, reset during replay, and QED disable in WAIT.
module tb_qed_dup_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        qed_ena;
    logic        qed_switch;
    logic        commit;
    logic        dup_mode;
    logic [4:0]  num_orig_insts;
    logic [4:0]  num_dup_insts;
    logic        wait_till_commit;
    logic        wait_till_commit_reg;
    logic        chk_en;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] fill_in  [DEPTH];
    logic [31:0] fill_exp [DEPTH];

    qed_dup_buffer_if bus ();

    qed_dup_buffer #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (bus),
        .qed_ena              (qed_ena),
        .qed_switch           (qed_switch),
        .commit               (commit),
        .dup_mode             (dup_mode),
        .num_orig_insts       (num_orig_insts),
        .num_dup_insts        (num_dup_insts),
        .wait_till_commit     (wait_till_commit),
        .wait_till_commit_reg (wait_till_commit_reg),
        .chk_en               (chk_en)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] inst, input logic out_ready,
                                 input logic sw, input logic cm);
        bus.inst_in_valid  = valid;
        bus.inst_in        = inst;
        bus.inst_out_ready = out_ready;
        qed_switch         = sw;
        commit             = cm;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            fill_in[i]  = 32'h0051_0093;
            fill_exp[i] = 32'h0059_0893;
        end
        fill_in[0] = 32'h0000_0033;  fill_exp[0] = 32'h0000_0033;
        fill_in[1] = 32'h0032_2023;
`ifdef QED_STORE_REMAP_EN
        fill_exp[1] = 32'h013A_2023;
`else
        fill_exp[1] = 32'h0000_0013;
`endif
        fill_in[2] = 32'h0031_00B3;  fill_exp[2] = 32'h0139_08B3;
        fill_in[3] = 32'h1234_52B7;  fill_exp[3] = 32'h1234_5AB7;
        fill_in[4] = 32'h0043_A303;  fill_exp[4] = 32'h004B_AB03;
        fill_in[5] = 32'h0080_00EF;  fill_exp[5] = 32'h0080_00EF;

        // Reset held with live inputs: everything must stay quiet.
        rst     = 1'b0;
        qed_ena = 1'b1;
        applyStimulus(1'b1, 32'h0051_0093, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("rst_out_valid", bus.inst_out_valid, 1'b0);
        checkOutput("rst_in_ready", bus.inst_in_ready, 1'b0);
        checkOutput("rst_inst_out", bus.inst_out, 32'h0);
        checkOutput("rst_dup_mode", dup_mode, 1'b0);
        checkOutput("rst_num_orig", num_orig_insts, 5'd0);
        checkOutput("rst_wait", wait_till_commit, 1'b0);
        checkOutput("rst_chk_en", chk_en, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Four originals, then an explicit switch.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h0051_0093, 1'b1, 1'b0, 1'b0);
            checkOutput("a_in_ready", bus.inst_in_ready, 1'b1);
            checkOutput("a_passthru", bus.inst_out, 32'h0051_0093);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("a_num_orig", num_orig_insts, 5'd4);
        checkOutput("a_chk_en", chk_en, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("a_dup_mode", dup_mode, 1'b1);
            checkOutput("a_dup_inst", bus.inst_out, 32'h0059_0893);
            checkOutput("a_dup_valid", bus.inst_out_valid, 1'b1);
            checkOutput("a_dup_in_ready", bus.inst_in_ready, 1'b0);
            tick();
        end
        checkOutput("a_wait", wait_till_commit, 1'b1);
        checkOutput("a_num_dup", num_dup_insts, 5'd4);
        checkOutput("a_wait_valid", bus.inst_out_valid, 1'b0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("a_wait_after7", wait_till_commit, 1'b1);
        checkOutput("a_pulse_after7", wait_till_commit_reg, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("a_pulse", wait_till_commit_reg, 1'b1);
        checkOutput("a_wait_done", wait_till_commit, 1'b0);
        checkOutput("a_clr_orig", num_orig_insts, 5'd0);
        checkOutput("a_clr_dup", num_dup_insts, 5'd0);
        tick();
        checkOutput("a_pulse_one", wait_till_commit_reg, 1'b0);

        // Full buffer with mixed opcodes, automatic switch, stall during replay.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, fill_in[i], 1'b1, 1'b0, 1'b0);
            checkOutput("b_in_ready", bus.inst_in_ready, 1'b1);
            checkOutput("b_num_orig", num_orig_insts, 5'(i));
            tick();
        end
        applyStimulus(1'b1, 32'h0051_0093, 1'b1, 1'b0, 1'b0);
        checkOutput("b_full_ready", bus.inst_in_ready, 1'b0);
        checkOutput("b_full_count", num_orig_insts, 5'd16);
        checkOutput("b_full_mode", dup_mode, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("b_auto_dup", dup_mode, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 2) begin
                applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
                for (int s = 0; s < 3; s++) begin
                    checkOutput("b_stall_inst", bus.inst_out, fill_exp[2]);
                    checkOutput("b_stall_valid", bus.inst_out_valid, 1'b1);
                    checkOutput("b_stall_dup", num_dup_insts, 5'd2);
                    tick();
                end
                applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            end
            checkOutput("b_dup_inst", bus.inst_out, fill_exp[i]);
            checkOutput("b_dup_count", num_dup_insts, 5'(i));
            tick();
        end
        checkOutput("b_wait", wait_till_commit, 1'b1);
        checkOutput("b_num_dup", num_dup_insts, 5'd16);
        for (int i = 0; i < 31; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("b_wait_31", wait_till_commit, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("b_pulse", wait_till_commit_reg, 1'b1);
        checkOutput("b_clr_orig", num_orig_insts, 5'd0);

        // Reset in DUP with two entries left, then a fresh one-entry pass.
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h0051_0093, 1'b1, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("c_pre_rst_dup", num_dup_insts, 5'd2);
        rst = 1'b0;
        #1;
        checkOutput("c_rst_mode", dup_mode, 1'b0);
        checkOutput("c_rst_valid", bus.inst_out_valid, 1'b0);
        checkOutput("c_rst_inst", bus.inst_out, 32'h0);
        checkOutput("c_rst_orig", num_orig_insts, 5'd0);
        checkOutput("c_rst_dup", num_dup_insts, 5'd0);
        tick();
        rst = 1'b1;
        applyStimulus(1'b1, 32'h00A0_0113, 1'b1, 1'b0, 1'b0);
        checkOutput("c_new_ready", bus.inst_in_ready, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("c_new_orig", num_orig_insts, 5'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("c_new_mode", dup_mode, 1'b1);
        checkOutput("c_new_inst", bus.inst_out, 32'h00A0_0913);
        tick();
        checkOutput("c_new_wait", wait_till_commit, 1'b1);

        // QED disabled while waiting: straight pass-through, nothing recorded.
        qed_ena = 1'b0;
        applyStimulus(1'b1, 32'h0032_2023, 1'b1, 1'b0, 1'b0);
        checkOutput("d_pass_inst", bus.inst_out, 32'h0032_2023);
        checkOutput("d_pass_valid", bus.inst_out_valid, 1'b1);
        checkOutput("d_pass_ready", bus.inst_in_ready, 1'b1);
        tick();
        checkOutput("d_wait_off", wait_till_commit, 1'b0);
        checkOutput("d_chk_en", chk_en, 1'b0);
        tick();
        checkOutput("d_no_record", num_orig_insts, 5'd0);
        checkOutput("d_mode", dup_mode, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
